// File: rtl/attack_sequencer.sv
// attack_sequencer
//   Per-player punch state machine sitting between keycode decode and the
//   knockback controllers. Each player steps IDLE -> STARTUP -> ACTIVE ->
//   RECOVERY -> IDLE. A hit stuns the victim and produces a single hit pulse
//   per attack. Simultaneous hits (trades) stun both players.
//
//   Optional feature macro: COMBO_COUNT_EN
//     defined   : ComboP1/ComboP2 count consecutive hits landed on a stunned
//                 victim (saturating at 15).
//     undefined : ComboP1/ComboP2 are tied to 0 and no combo logic exists.
//
// Ports
//   frame_clk              frame clock (vsync), the only clock
//   Reset                  asynchronous active-low reset
//   PunchReqP1/P2          punch key held
//   InRangeP1/P2           that player's fist reaches the opponent
//   PunchP1/P2             attack animation (STARTUP, ACTIVE or RECOVERY)
//   PhaseP1/P2 [2:0]       0 IDLE, 1 STARTUP, 2 ACTIVE, 3 RECOVERY, 4 STUN
//   hitP1/P2               one-frame pulse: that player was hit
//   ComboP1/P2 [3:0]       consecutive hits landed by that player
module attack_sequencer #(
  parameter int STARTUP_FRAMES  = 3,
  parameter int ACTIVE_FRAMES   = 4,
  parameter int RECOVERY_FRAMES = 8,
  parameter int STUN_FRAMES     = 12,
  parameter int CNT_W           = 6
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       PunchReqP1,
  input  logic       PunchReqP2,
  input  logic       InRangeP1,
  input  logic       InRangeP2,
  output logic       PunchP1,
  output logic       PunchP2,
  output logic [2:0] PhaseP1,
  output logic [2:0] PhaseP2,
  output logic       hitP1,
  output logic       hitP2,
  output logic [3:0] ComboP1,
  output logic [3:0] ComboP2
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_STARTUP  = 3'd1;
  localparam logic [2:0] S_ACTIVE   = 3'd2;
  localparam logic [2:0] S_RECOVERY = 3'd3;
  localparam logic [2:0] S_STUN     = 3'd4;

  // counters load N-1 so each phase lasts exactly N frames
  localparam logic [CNT_W-1:0] LD_STARTUP  = CNT_W'(STARTUP_FRAMES - 1);
  localparam logic [CNT_W-1:0] LD_ACTIVE   = CNT_W'(ACTIVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] LD_RECOVERY = CNT_W'(RECOVERY_FRAMES - 1);
  localparam logic [CNT_W-1:0] LD_STUN     = CNT_W'(STUN_FRAMES - 1);

  // index 0 = P1, index 1 = P2
  logic [1:0]      w_req, w_inr, w_fire, w_landed, w_cnt_z, w_hit, w_punch;
  logic [1:0][2:0] w_state;
  logic [1:0][3:0] w_combo;

  assign w_req = {PunchReqP2, PunchReqP1};
  assign w_inr = {InRangeP2, InRangeP1};

  for (genvar p = 0; p < 2; p++) begin : g_plr
    localparam int O = 1 - p;  // opponent index

    logic [2:0]       r_state, w_nstate;
    logic [CNT_W-1:0] r_cnt, w_ncnt;
    logic             r_req_q, r_landed, r_hit, r_punch;
    logic             w_trig;

    assign w_trig      = w_req[p] & ~r_req_q;
    assign w_state[p]  = r_state;
    assign w_landed[p] = r_landed;
    assign w_cnt_z[p]  = (r_cnt == '0);
    // this player lands a hit on the coming edge (pre-edge state only)
    assign w_fire[p]   = (r_state == S_ACTIVE) & w_inr[p] & ~r_landed;
    assign w_hit[p]    = r_hit;
    assign w_punch[p]  = r_punch;

    always_comb begin
      w_nstate = r_state;
      w_ncnt   = r_cnt;
      if (w_fire[O]) begin
        // being hit overrides everything, including an ongoing stun
        w_nstate = S_STUN;
        w_ncnt   = LD_STUN;
      end else begin
        case (r_state)
          S_IDLE: if (w_trig) begin
            w_nstate = S_STARTUP;
            w_ncnt   = LD_STARTUP;
          end
          S_STARTUP:
            if (w_cnt_z[p]) begin w_nstate = S_ACTIVE;   w_ncnt = LD_ACTIVE;   end
            else            w_ncnt = r_cnt - 1'b1;
          S_ACTIVE:
            if (w_cnt_z[p]) begin w_nstate = S_RECOVERY; w_ncnt = LD_RECOVERY; end
            else            w_ncnt = r_cnt - 1'b1;
          S_RECOVERY, S_STUN:
            if (w_cnt_z[p]) w_nstate = S_IDLE;
            else            w_ncnt = r_cnt - 1'b1;
          default: begin
            w_nstate = S_IDLE;
            w_ncnt   = '0;
          end
        endcase
      end
    end

    always_ff @(posedge frame_clk or negedge Reset) begin
      if (!Reset) begin
        r_state  <= S_IDLE;
        r_cnt    <= '0;
        r_req_q  <= 1'b0;
        r_landed <= 1'b0;
        r_hit    <= 1'b0;
        r_punch  <= 1'b0;
      end else begin
        r_state <= w_nstate;
        r_cnt   <= w_ncnt;
        r_req_q <= w_req[p];
        r_hit   <= w_fire[O];
        r_punch <= (w_nstate == S_STARTUP) | (w_nstate == S_ACTIVE) |
                   (w_nstate == S_RECOVERY);
        if (r_state == S_IDLE && w_nstate == S_STARTUP) r_landed <= 1'b0;
        else if (w_fire[p])                             r_landed <= 1'b1;
      end
    end

`ifdef COMBO_COUNT_EN
    logic [3:0] r_combo;
    // victim leaves stun this edge; a fresh hit would reload it instead
    logic       w_opp_exit;
    assign w_opp_exit = (w_state[O] == S_STUN) & w_cnt_z[O] & ~w_fire[p];

    always_ff @(posedge frame_clk or negedge Reset) begin
      if (!Reset) begin
        r_combo <= 4'd0;
      end else if (w_fire[p]) begin
        if (w_state[O] == S_STUN)
          r_combo <= (r_combo == 4'd15) ? 4'd15 : r_combo + 4'd1;
        else
          r_combo <= 4'd1;
      end else if (w_opp_exit) begin
        r_combo <= 4'd0;
      end
    end
    assign w_combo[p] = r_combo;
`else
    assign w_combo[p] = 4'd0;
`endif
  end

  assign PunchP1 = w_punch[0];
  assign PunchP2 = w_punch[1];
  assign PhaseP1 = w_state[0];
  assign PhaseP2 = w_state[1];
  assign hitP1   = w_hit[0];
  assign hitP2   = w_hit[1];
  assign ComboP1 = w_combo[0];
  assign ComboP2 = w_combo[1];

endmodule
